fir_mac_datapath: RTL and testbench
===================================

# fir_mac_datapath

Datapath for the FIR filter core, driven directly by the `fsm` controller. It holds the sample shift register, the working/shadow coefficient banks, the tap and sample counters, and the MAC accumulator. It returns `Petla_full` / `Licznik_full` to the controller and writes one rounded output sample per input sample to the output buffer.

## Interface

Parameters:
- `DATA_W`, 16: sample and output width (signed).
- `COEF_W`, 16: coefficient width (signed).
- `TAPS`, 16: filter length; must be ≥ 2.
- `N_MAX`, 256: maximum samples per run.
- `FRAC_BITS`, 15: right shift applied to the accumulator on output; must be ≥ 1.
- `ACC_W`, DATA_W+COEF_W+$clog2(TAPS): accumulator width.

Ports:
- `clk`, in, 1: clock. One clock domain; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cfg_len`, in, $clog2(N_MAX)+1: run length, 1..N_MAX.
- `coef_we`, in, 1: shadow coefficient write strobe.
- `coef_waddr`, in, $clog2(TAPS): shadow bank address.
- `coef_wdata`, in, COEF_W: coefficient value.
- `smp_raddr`, out, $clog2(N_MAX): input buffer read address.
- `smp_rdata`, in, DATA_W: input buffer data, valid one cycle after `smp_raddr`.
- `out_we`, out, 1: output buffer write strobe.
- `out_addr`, out, $clog2(N_MAX): output buffer address.
- `out_data`, out, DATA_W: filtered sample.
- `FSM_zapisz_wsp`, `FSM_zapisz_probki`, `FSM_reset_petla`, `FSM_petla_en`, `FSM_reset_licznik`, `FSM_nowa_probka`, `FSM_reset_shift`, `FSM_nowa_shift`, `FSM_reset_Acc`, `FSM_Acc_en`, `FSM_Acc_zapisz`: in, 1 each. Controller commands.
- `Petla_full`, out, 1: tap counter at last tap.
- `Licznik_full`, out, 1: sample counter at last sample.

## Operation

Counters:
- **Tap counter `k`**, range 0..TAPS-1.
  - `FSM_reset_petla` sets it to 0.
  - Otherwise `FSM_petla_en` increments it, saturating at TAPS-1.
  - `Petla_full` = (k == TAPS-1), combinational from the register.
- **Sample counter `n`**, range 0..N_MAX-1.
  - `FSM_reset_licznik` sets it to 0.
  - Otherwise `FSM_nowa_probka` increments it, saturating at `len_q`-1.
  - `Licznik_full` = (n == `len_q`-1).
  - `smp_raddr` = n.
- **Length register `len_q`**: `FSM_zapisz_probki` loads it from `cfg_len`. Values 0 or > N_MAX are clamped to N_MAX.

Coefficient banks:
- `coef_we` writes the shadow bank at any time.
- `FSM_zapisz_wsp` copies the whole shadow bank into the working bank in one edge.
- If `coef_we` and `FSM_zapisz_wsp` are asserted in the same cycle, the working bank gets the pre-write shadow value.

Shift register, TAPS × DATA_W:
- `FSM_reset_shift` clears it to 0.
- Otherwise `FSM_nowa_shift` shifts it: `sh[0]` ← `smp_rdata`, `sh[i]` ← `sh[i-1]`.

Accumulator and output:
- **MAC:** when `FSM_Acc_en` is high, acc ← acc + sh[k] × wc[k], signed, full-precision product, sign-extended to ACC_W.
- **Accumulator priority:** `FSM_reset_Acc` > `FSM_Acc_zapisz` > `FSM_Acc_en`.
- **Output write:** `FSM_Acc_zapisz` computes r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift), reduces r to DATA_W, and registers `out_data` ← r, `out_addr` ← n, `out_we` ← 1. The same edge clears acc to 0.
- **Strobe length:** `out_we` is high for exactly one cycle per `FSM_Acc_zapisz`.

Reset and simultaneous commands:
- Reset and clear commands take priority over enables for the same register.
- `rst_n` low mid-run clears everything immediately, including any pending `out_we`. Nothing is written after reset.

## Timing

Reset values:
- k = 0, n = 0, acc = 0, shift register = 0, both coefficient banks = 0, `len_q` = N_MAX.
- `out_we` = 0, `out_addr` = 0, `out_data` = 0, `smp_raddr` = 0.
- `Petla_full` = 0, `Licznik_full` = 0.

Latencies:
- **`smp_rdata`:** must be valid in the cycle `FSM_nowa_shift` is high. The controller guarantees at least one cycle between a change of `n` and the next `FSM_nowa_shift`.
- **MAC loop:** exactly TAPS cycles of `FSM_petla_en`/`FSM_Acc_en` starting from k = 0. The last MAC happens in the cycle `Petla_full` = 1.
- **Output write:** `out_we` rises on the edge after `FSM_Acc_zapisz`; `out_data` and `out_addr` are valid in the same cycle.
- **Full flags:** both are combinational from registers; no added latency.

## Configuration

- **`FIR_SATURATE_EN` defined:** r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- **`FIR_SATURATE_EN` undefined:** r is truncated to its low DATA_W bits (two's-complement wrap).

## Test plan

- **Impulse response.** TAPS = 4, coefficients {0x4000, 0x2000, 0x1000, 0x0800}, input {0x7FFF, 0, 0, 0, 0}, `cfg_len` = 5 → `out_data` = {0x4000, 0x2000, 0x1000, 0x0800, 0} (rounded) at `out_addr` 0..4. Exactly five `out_we` pulses.
- **Saturation.** All coefficients 0x7FFF, all inputs 0x7FFF → with `FIR_SATURATE_EN`: `out_data` = 0x7FFF. Without it: the low 16 bits of the rounded result.
- **Shadow bank.** `coef_we` during a run → outputs are unchanged until the next `FSM_zapisz_wsp`. `coef_we` in the same cycle as `FSM_zapisz_wsp` → the old value is used.
- **Flags.** `cfg_len` = 1 → `Licznik_full` = 1 right after `FSM_zapisz_probki`. `cfg_len` = 0 → clamped to N_MAX. `Petla_full` asserts after TAPS-1 increments and k holds at TAPS-1.
- **Priority.** `FSM_reset_Acc` together with `FSM_Acc_en` → acc = 0. `FSM_reset_petla` together with `FSM_petla_en` → k = 0.
- **Reset mid-run.** `rst_n` low during the MAC loop → all outputs return to their reset values asynchronously and no `out_we` follows.

Source files
------------

// File: rtl/fir_mac_datapath.sv
// fir_mac_datapath: FIR sample shift register, shadow/working coefficient banks, counters and MAC.
// Define FIR_SATURATE_EN to clamp the rounded output instead of wrapping it.
module fir_mac_datapath #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int N_MAX     = 256,
  parameter int FRAC_BITS = 15,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(N_MAX):0]     cfg_len,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_waddr,
  input  logic [COEF_W-1:0]          coef_wdata,
  output logic [$clog2(N_MAX)-1:0]   smp_raddr,
  input  logic [DATA_W-1:0]          smp_rdata,
  output logic                       out_we,
  output logic [$clog2(N_MAX)-1:0]   out_addr,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       FSM_zapisz_wsp,
  input  logic                       FSM_zapisz_probki,
  input  logic                       FSM_reset_petla,
  input  logic                       FSM_petla_en,
  input  logic                       FSM_reset_licznik,
  input  logic                       FSM_nowa_probka,
  input  logic                       FSM_reset_shift,
  input  logic                       FSM_nowa_shift,
  input  logic                       FSM_reset_Acc,
  input  logic                       FSM_Acc_en,
  input  logic                       FSM_Acc_zapisz,
  output logic                       Petla_full,
  output logic                       Licznik_full
);
  localparam int KW = $clog2(TAPS);
  localparam int AW = $clog2(N_MAX);
  localparam int LW = AW + 1;
  localparam int PW = DATA_W + COEF_W;
  logic [KW-1:0] k;
  logic [AW-1:0] n;
  logic [LW-1:0] len_q, len_last;
  logic signed [DATA_W-1:0] sh [TAPS];
  logic signed [COEF_W-1:0] sc [TAPS];
  logic signed [COEF_W-1:0] wc [TAPS];
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc, mac, acc_rnd, r;
  logic [DATA_W-1:0] r_red;
`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif
  assign len_last     = len_q - LW'(1);
  assign Petla_full   = (k == KW'(TAPS - 1));
  assign Licznik_full = ({1'b0, n} == len_last);
  assign smp_raddr    = n;
  always_comb begin
    prod    = sh[k] * wc[k];
    mac     = {{(ACC_W-PW){prod[PW-1]}}, prod};
    acc_rnd = acc + (ACC_W'(1) << (FRAC_BITS - 1));
    r       = acc_rnd >>> FRAC_BITS;
`ifdef FIR_SATURATE_EN
    r_red   = (r > MAX_V) ? MAX_V[DATA_W-1:0] : (r < MIN_V) ? MIN_V[DATA_W-1:0] : r[DATA_W-1:0];
`else
    r_red   = r[DATA_W-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      n     <= '0;
      len_q <= LW'(N_MAX);
    end else begin
      if (FSM_reset_petla) k <= '0;
      else if (FSM_petla_en) k <= Petla_full ? k : k + KW'(1);
      if (FSM_reset_licznik) n <= '0;
      else if (FSM_nowa_probka) n <= ({1'b0, n} < len_last) ? n + AW'(1) : n;
      if (FSM_zapisz_probki)
        len_q <= (cfg_len == '0 || cfg_len > LW'(N_MAX)) ? LW'(N_MAX) : cfg_len;
    end
  end
  // Non-blocking copy means a same-edge shadow write lands after the working bank samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        sc[i] <= '0;
        wc[i] <= '0;
        sh[i] <= '0;
      end
    end else begin
      if (coef_we) sc[coef_waddr] <= coef_wdata;
      if (FSM_zapisz_wsp) wc <= sc;
      if (FSM_reset_shift) begin
        for (int i = 0; i < TAPS; i++) sh[i] <= '0;
      end else if (FSM_nowa_shift) begin
        sh[0] <= smp_rdata;
        for (int i = 1; i < TAPS; i++) sh[i] <= sh[i-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (FSM_reset_Acc || FSM_Acc_zapisz) acc <= '0;
      else if (FSM_Acc_en) acc <= acc + mac;
      out_we <= FSM_Acc_zapisz;
      if (FSM_Acc_zapisz) begin
        out_data <= r_red;
        out_addr <= n;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_datapath.sv
// tb_fir_mac_datapath: drives controller commands and checks outputs against a convolution model.
module tb_fir_mac_datapath;
  logic clk, rst_n;
  logic [4:0] cfg_len;
  logic coef_we;
  logic [1:0] coef_waddr;
  logic [15:0] coef_wdata, smp_rdata, out_data;
  logic [3:0] smp_raddr, out_addr;
  logic out_we, Petla_full, Licznik_full;
  logic FSM_zapisz_wsp, FSM_zapisz_probki, FSM_reset_petla, FSM_petla_en, FSM_reset_licznik;
  logic FSM_nowa_probka, FSM_reset_shift, FSM_nowa_shift, FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapisz;
  typedef struct { logic [3:0] a; logic [15:0] d; } out_t;
  typedef struct { logic [15:0] x; logic [15:0] y; } vec_t;
  out_t outq[$];
  int pulses = 0, tests = 0, fails = 0;
  logic [15:0] mem [16];
  logic signed [15:0] shadow_m [4];
  logic signed [15:0] work_m [4];
  fir_mac_datapath #(.DATA_W(16), .COEF_W(16), .TAPS(4), .N_MAX(16), .FRAC_BITS(15)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .coef_we(coef_we), .coef_waddr(coef_waddr),
    .coef_wdata(coef_wdata), .smp_raddr(smp_raddr), .smp_rdata(smp_rdata), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .FSM_zapisz_wsp(FSM_zapisz_wsp),
    .FSM_zapisz_probki(FSM_zapisz_probki), .FSM_reset_petla(FSM_reset_petla),
    .FSM_petla_en(FSM_petla_en), .FSM_reset_licznik(FSM_reset_licznik),
    .FSM_nowa_probka(FSM_nowa_probka), .FSM_reset_shift(FSM_reset_shift),
    .FSM_nowa_shift(FSM_nowa_shift), .FSM_reset_Acc(FSM_reset_Acc), .FSM_Acc_en(FSM_Acc_en),
    .FSM_Acc_zapisz(FSM_Acc_zapisz), .Petla_full(Petla_full), .Licznik_full(Licznik_full));
  always #5 clk = ~clk;
  always @(posedge clk) smp_rdata <= mem[smp_raddr];
  always @(negedge clk) if (out_we) begin
    outq.push_back('{out_addr, out_data});
    pulses++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic clr();
    {FSM_zapisz_wsp, FSM_zapisz_probki, FSM_reset_petla, FSM_petla_en, FSM_reset_licznik,
     FSM_nowa_probka, FSM_reset_shift, FSM_nowa_shift, FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapisz} = '0;
    coef_we = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask
  task automatic write_coef(int a, logic [15:0] v);
    coef_we = 1; coef_waddr = 2'(a); coef_wdata = v; shadow_m[a] = v;
    step();
  endtask
  task automatic commit();
    FSM_zapisz_wsp = 1; work_m = shadow_m;
    step();
  endtask
  // Reference: y[n] = round(sum_j c[j]*x[n-j] / 2^15), x before the run start taken as zero
  function automatic logic [15:0] model_y(int idx);
    longint s = 0;
    for (int j = 0; j < 4; j++)
      if (idx - j >= 0) s += longint'($signed(mem[idx-j])) * longint'(work_m[j]);
    s = (s + 64'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction
  task automatic run(int len, bit mw);
    cfg_len = 5'(len);
    FSM_zapisz_probki = 1; FSM_reset_licznik = 1; FSM_reset_shift = 1; FSM_reset_Acc = 1;
    step();
    outq.delete();
    for (int s = 0; s < len; s++) begin
      if (mw && s == 1) begin
        coef_we = 1; coef_waddr = 0; coef_wdata = 16'($urandom); shadow_m[0] = coef_wdata;
      end
      step();
      FSM_nowa_shift = 1; FSM_reset_petla = 1;
      step();
      repeat (4) begin
        FSM_petla_en = 1; FSM_Acc_en = 1;
        step();
      end
      FSM_Acc_zapisz = 1;
      step();
      FSM_nowa_probka = 1;
      step();
    end
    chk("out_we_count", outq.size(), len);
    chk("licznik_full_end", Licznik_full, 1);
    for (int i = 0; i < outq.size() && i < len; i++) begin
      chk("out_addr", outq[i].a, i);
      chk("out_data", outq[i].d, model_y(i));
    end
  endtask
  initial begin
    vec_t tbl [5];
    logic [15:0] sat_exp, v1;
    int p0;
    tbl = '{'{16'h7FFF, 16'h4000}, '{16'h0000, 16'h2000}, '{16'h0000, 16'h1000},
            '{16'h0000, 16'h0800}, '{16'h0000, 16'h0000}};
`ifdef FIR_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hFFF8;
`endif
    clk = 0; rst_n = 0; cfg_len = 0; coef_waddr = 0; coef_wdata = 0;
    clr();
    for (int i = 0; i < 16; i++) mem[i] = 0;
    for (int i = 0; i < 4; i++) begin shadow_m[i] = 0; work_m[i] = 0; end
    #12;
    chk("rst_out_we", out_we, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_smp_raddr", smp_raddr, 0);
    chk("rst_petla_full", Petla_full, 0);
    chk("rst_licznik_full", Licznik_full, 0);
    rst_n = 1;
    step();
    // impulse response, table driven
    for (int i = 0; i < 5; i++) mem[i] = tbl[i].x;
    write_coef(0, 16'h4000); write_coef(1, 16'h2000); write_coef(2, 16'h1000); write_coef(3, 16'h0800);
    commit();
    run(5, 0);
    for (int i = 0; i < 5; i++)
      if (i < outq.size()) chk("impulse_data", outq[i].d, tbl[i].y);
    // saturation / wrap
    for (int i = 0; i < 16; i++) mem[i] = 16'h7FFF;
    for (int a = 0; a < 4; a++) write_coef(a, 16'h7FFF);
    commit();
    run(4, 0);
    if (outq.size() == 4) chk("sat_data", outq[3].d, sat_exp);
    // accumulator clear wins over enable
    outq.delete();
    FSM_reset_Acc = 1; FSM_reset_petla = 1; step();
    repeat (2) begin FSM_petla_en = 1; FSM_Acc_en = 1; step(); end
    FSM_reset_Acc = 1; FSM_Acc_en = 1; step();
    FSM_Acc_zapisz = 1; step();
    step();
    chk("acc_prio_we", outq.size(), 1);
    if (outq.size() == 1) chk("acc_prio_data", outq[0].d, 0);
    // tap counter flag, saturation and clear priority
    FSM_reset_petla = 1; step();
    chk("petla_k0", Petla_full, 0);
    repeat (2) begin FSM_petla_en = 1; step(); end
    chk("petla_k2", Petla_full, 0);
    FSM_petla_en = 1; step();
    chk("petla_k3", Petla_full, 1);
    FSM_petla_en = 1; step();
    chk("petla_hold", Petla_full, 1);
    FSM_reset_petla = 1; FSM_petla_en = 1; step();
    chk("petla_prio", Petla_full, 0);
    // sample counter flags and length clamping
    cfg_len = 1; FSM_zapisz_probki = 1; FSM_reset_licznik = 1; step();
    chk("licznik_len1", Licznik_full, 1);
    cfg_len = 0; FSM_zapisz_probki = 1; FSM_reset_licznik = 1; step();
    chk("licznik_len0", Licznik_full, 0);
    repeat (14) begin FSM_nowa_probka = 1; step(); end
    chk("licznik_14", Licznik_full, 0);
    FSM_nowa_probka = 1; step();
    chk("licznik_15", Licznik_full, 1);
    FSM_nowa_probka = 1; step();
    chk("licznik_sat", Licznik_full, 1);
    chk("raddr_sat", smp_raddr, 15);
    cfg_len = 20; FSM_zapisz_probki = 1; FSM_reset_licznik = 1; step();
    repeat (14) begin FSM_nowa_probka = 1; step(); end
    chk("licznik_clamp_14", Licznik_full, 0);
    FSM_nowa_probka = 1; step();
    chk("licznik_clamp_15", Licznik_full, 1);
    // random runs against the model
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      for (int a = 0; a < 4; a++) write_coef(a, 16'($urandom));
      commit();
      run(int'($urandom_range(1, 16)), 0);
    end
    // shadow writes during a run stay invisible; same-edge write loses to the copy
    run(6, 1);
    v1 = shadow_m[0];
    coef_we = 1; coef_waddr = 0; coef_wdata = v1 ^ 16'h1234; FSM_zapisz_wsp = 1;
    work_m = shadow_m; shadow_m[0] = coef_wdata;
    step();
    run(4, 0);
    commit();
    run(4, 0);
    // asynchronous reset while an output strobe is pending
    cfg_len = 1; FSM_zapisz_probki = 1; FSM_reset_licznik = 1; step();
    FSM_reset_Acc = 1; FSM_reset_petla = 1; step();
    repeat (4) begin FSM_petla_en = 1; FSM_Acc_en = 1; step(); end
    p0 = pulses;
    FSM_Acc_zapisz = 1; step();
    chk("pre_rst_we", out_we, 1);
    chk("pre_rst_petla", Petla_full, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_out_we", out_we, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_petla", Petla_full, 0);
    chk("arst_licznik", Licznik_full, 0);
    chk("arst_raddr", smp_raddr, 0);
    #3 rst_n = 1;
    repeat (5) step();
    chk("arst_no_we", pulses, p0);
    for (int i = 0; i < 4; i++) begin shadow_m[i] = 0; work_m[i] = 0; end
    run(3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
